dbus_responder: RTL and testbench
=================================

DBUS_RESPONDER -- requirements
Module: dbus_responder

Interface
REQ-001 Parameter MEM_WORDS, default 1024, meaning: depth of backing store in 64-bit words (power of two, >=2).
REQ-002 Parameter LATENCY, default 2, meaning: cycles from request capture to response (legal 1..15).
REQ-003 Port clk  input  1  single clock; all state updates on posedge clk.
REQ-004 Port rst  input  1  reset, asynchronous, active-low.
REQ-005 Port dreq  input  dbus_req_t  fields: valid, addr (64), size (msize_t), strobe (8), data (64).
REQ-006 Port dresp  output  dbus_resp_t  fields: addr_ok, data_ok, data (64).
REQ-007 Port busy  output  1  high while a request is captured and not yet answered.
REQ-008 Port txn_count  output  32  number of completed transactions since reset.

Function
REQ-009 FSM states: IDLE, WAIT, RESP; reset state IDLE.
REQ-010 IDLE: if dreq.valid, capture addr, strobe, data into holding registers, load counter with LATENCY-1, go to WAIT (or RESP if LATENCY==1).
REQ-011 WAIT: decrement counter each cycle; counter==0 -> RESP next cycle.
REQ-012 RESP: assert dresp.addr_ok=1 and dresp.data_ok=1 for exactly this one cycle, then IDLE.
REQ-013 Response cycle is LATENCY cycles after capture cycle (capture at cycle N -> RESP at cycle N+LATENCY).
REQ-014 Word index = captured addr[3 +: log2(MEM_WORDS)]; addr[2:0] and upper bits ignored (wrap-around modulo MEM_WORDS).
REQ-015 Read (strobe==0): dresp.data = full stored 64-bit word at index; byte extraction is the requester's job.
REQ-016 Write (strobe!=0): in RESP cycle, byte lane i of word updated with data[8i+7:8i] iff strobe[i]; dresp.data = word contents before the write.
REQ-017 dresp.size is not interpreted beyond pass-through; strobe alone selects written bytes.
REQ-018 Outside RESP: addr_ok=0, data_ok=0, dresp.data=0.
REQ-019 Requester holds dreq stable while valid until data_ok; responder samples only at capture.
REQ-020 Abort: dreq.valid low in WAIT or RESP -> return to IDLE next cycle, no write, no data_ok, txn_count unchanged.
REQ-021 After RESP, minimum one IDLE cycle before next capture (a valid held in the RESP cycle is not captured that cycle).
REQ-022 busy=1 in WAIT and RESP, 0 in IDLE.
REQ-023 txn_count increments by 1 at each RESP cycle; wraps 0xFFFF_FFFF -> 0.
REQ-024 Memory array is not cleared by reset; contents persist across reset.

Reset
REQ-025 rst low asynchronously forces IDLE, counter=0, holding registers=0, txn_count=0, all dresp fields 0, busy=0.
REQ-026 Reset asserted in WAIT or RESP cancels the transaction; a pending write is not performed.
REQ-027 First capture possible on the first posedge after rst rises.

Verification
REQ-028 LATENCY=2: write addr 0x10, strobe 0xFF, data 0x1122334455667788 at cycle N -> data_ok only at N+2, data = old word; txn_count=1.
REQ-029 Then read addr 0x10 -> data 0x1122334455667788; then write strobe 0x01, data 0xAA -> following read returns 0x11223344556677AA.
REQ-030 Wrap: MEM_WORDS=1024, write addr 0x2000 data 0x5 -> read addr 0x0 returns 0x5.
REQ-031 Abort: valid dropped one cycle after capture with strobe 0xFF -> no data_ok, memory unchanged, txn_count unchanged, busy=0 next cycle.
REQ-032 Reset in WAIT during write: rst low 1 cycle -> all outputs 0, txn_count=0, target word unchanged on later read.
REQ-033 Back-to-back: valid held across two requests at LATENCY=1 -> data_ok pulses separated by at least one low cycle, each exactly one cycle wide.

Source files
------------

// File: rtl/dbus_responder.sv
// Data-bus responder: single-outstanding request, fixed LATENCY, 64-bit word store
// with byte-strobed writes that return the pre-write word.
package dbus_pkg;
    typedef enum logic [1:0] {
        MSIZE1 = 2'd0,
        MSIZE2 = 2'd1,
        MSIZE4 = 2'd2,
        MSIZE8 = 2'd3
    } msize_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        msize_t      size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;
endpackage

module dbus_responder
    import dbus_pkg::*;
#(
    parameter int MEM_WORDS = 1024,
    parameter int LATENCY   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  dbus_req_t   dreq,
    output dbus_resp_t  dresp,
    output logic        busy,
    output logic [31:0] txn_count
);

    localparam int         ADDR_W = $clog2(MEM_WORDS);
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [7:0]          strb_q, strb_d;
    logic [63:0]         wdata_q, wdata_d;
    logic [31:0]         txn_q, txn_d;
    logic [63:0]         mem_q [MEM_WORDS];
    logic                mem_we;
    logic [63:0]         rd_word;
    logic                unused_bits;

    // Size is pass-through only; sub-word address bits and bits above the index wrap away.
    assign unused_bits = ^{dreq.size, dreq.addr[2:0], dreq.addr[63:ADDR_W+3]};

    function automatic logic [63:0] merge_bytes(input logic [63:0] old_w,
                                                input logic [63:0] new_w,
                                                input logic [7:0]  strb);
        logic [63:0] merged;
        merged = old_w;
        for (int i = 0; i < 8; i++) begin
            if (strb[i]) merged[8*i +: 8] = new_w[8*i +: 8];
        end
        return merged;
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        strb_d  = strb_q;
        wdata_d = wdata_q;
        txn_d   = txn_q;
        dresp   = '0;
        mem_we  = 1'b0;
        rd_word = mem_q[idx_q];

        case (state_q)
            IDLE: begin
                if (dreq.valid) begin
                    idx_d   = dreq.addr[3 +: ADDR_W];
                    strb_d  = dreq.strobe;
                    wdata_d = dreq.data;
                    cnt_d   = LAT_M1;
                    state_d = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (!dreq.valid) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    // Counter reaches zero on this edge, so the response lands LATENCY after capture.
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
                if (dreq.valid) begin
                    dresp.addr_ok = 1'b1;
                    dresp.data_ok = 1'b1;
                    dresp.data    = rd_word;
                    mem_we        = (strb_q != 8'd0);
                    txn_d         = txn_q + 32'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            strb_q  <= '0;
            wdata_q <= '0;
            txn_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            strb_q  <= strb_d;
            wdata_q <= wdata_d;
            txn_q   <= txn_d;
        end
    end

    // Backing store deliberately has no reset so contents survive it.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[idx_q] <= merge_bytes(rd_word, wdata_q, strb_q);
    end

    assign busy      = (state_q != IDLE);
    assign txn_count = txn_q;

endmodule

// File: tb/tb_dbus_responder.sv
// Randomized bench for dbus_responder: directed scenarios plus random traffic against
// a word-map reference model; a second instance at LATENCY=1 covers back-to-back requests.
module tb_dbus_responder;
    import dbus_pkg::*;

    localparam int MEM_WORDS = 1024;
    localparam int LAT       = 2;
    localparam int MW1       = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    dbus_req_t   req, req1;
    dbus_resp_t  resp, resp1;
    logic        busy, busy1;
    logic [31:0] txn, txn1;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] mem_m [int];
    logic [31:0] txn_m = 32'd0;

    always #5 clk = ~clk;

    dbus_responder #(.MEM_WORDS(MEM_WORDS), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .dreq(req), .dresp(resp), .busy(busy), .txn_count(txn)
    );

    dbus_responder #(.MEM_WORDS(MW1), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .dreq(req1), .dresp(resp1), .busy(busy1), .txn_count(txn1)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int word_of(input logic [63:0] a);
        return int'((a / 64'd8) % 64'(MEM_WORDS));
    endfunction

    function automatic logic [63:0] apply_strobe(input logic [63:0] old_w, input logic [63:0] d,
                                                 input logic [7:0] strb);
        logic [63:0] r;
        r = old_w;
        for (int b = 0; b < 8; b++) begin
            if (strb[b]) r[8*b +: 8] = d[8*b +: 8];
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full transaction; called at 1 time unit after a posedge with the DUT idle.
    task automatic do_txn(input logic [63:0] addr, input logic [7:0] strb, input logic [63:0] d);
        int          w;
        int          cyc;
        bit          known;
        logic [63:0] old_w;
        w     = word_of(addr);
        known = mem_m.exists(w);
        old_w = known ? mem_m[w] : 64'd0;
        req.valid  = 1'b1;
        req.addr   = addr;
        req.size   = MSIZE8;
        req.strobe = strb;
        req.data   = d;
        cyc = 0;
        while (cyc < 20) begin
            step();
            cyc++;
            check_eq("busy_pending", 64'(busy), 64'd1);
            if (resp.data_ok) break;
        end
        check_eq("latency", 64'(cyc), 64'(LAT));
        check_eq("addr_ok", 64'(resp.addr_ok), 64'd1);
        if (known) check_eq("rdata", resp.data, old_w);
        step();
        req.valid = 1'b0;
        #1;
        check_eq("dok_one_cycle", 64'(resp.data_ok), 64'd0);
        check_eq("idle_data", resp.data, 64'd0);
        check_eq("busy_after", 64'(busy), 64'd0);
        if (strb == 8'hFF) mem_m[w] = d;
        else if (strb != 8'h00 && known) mem_m[w] = apply_strobe(old_w, d, strb);
        else if (strb != 8'h00) mem_m.delete(w);
        txn_m = txn_m + 32'd1;
        check_eq("txn_count", 64'(txn), 64'(txn_m));
    endtask

    // Drop valid while waiting (stage 1) or in the response cycle (stage 2).
    task automatic abort_txn(input logic [63:0] addr, input logic [7:0] strb, input logic [63:0] d,
                             input int stage);
        req.valid  = 1'b1;
        req.addr   = addr;
        req.size   = MSIZE8;
        req.strobe = strb;
        req.data   = d;
        step();
        check_eq("abort_busy", 64'(busy), 64'd1);
        check_eq("abort_wait_dok", 64'(resp.data_ok), 64'd0);
        if (stage == 2) step();
        req.valid = 1'b0;
        #1;
        check_eq("abort_dok", 64'(resp.data_ok), 64'd0);
        check_eq("abort_data", resp.data, 64'd0);
        step();
        check_eq("abort_busy_after", 64'(busy), 64'd0);
        check_eq("abort_txn", 64'(txn), 64'(txn_m));
    endtask

    function automatic logic [63:0] rand_addr(input int w);
        logic [63:0] a;
        a = {$urandom, $urandom};
        a = (a & ~64'h1FF8) | (64'(w) << 3);
        return a;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1);
    end

    initial begin
        logic [63:0] d;
        int          r;
        req  = '0;
        req1 = '0;
        repeat (2) step();
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_txn", 64'(txn), 64'd0);
        check_eq("rst_dok", 64'({resp.addr_ok, resp.data_ok}), 64'd0);
        check_eq("rst_data", resp.data, 64'd0);
        rst = 1'b1;

        for (int w = 0; w < 8; w++) do_txn(64'(w) << 3, 8'hFF, {$urandom, $urandom});

        do_txn(64'h10, 8'hFF, 64'h1122334455667788);
        do_txn(64'h10, 8'h00, 64'h0);
        do_txn(64'h10, 8'h01, 64'hAA);
        do_txn(64'h10, 8'h00, 64'h0);
        check_eq("partial_write", mem_m[2], 64'h11223344556677AA);

        do_txn(64'h2000, 8'hFF, 64'h5);
        do_txn(64'h0, 8'h00, 64'h0);

        abort_txn(64'h8, 8'hFF, 64'hDEADBEEFCAFEF00D, 1);
        do_txn(64'h8, 8'h00, 64'h0);
        abort_txn(64'h8, 8'hFF, 64'h0123456789ABCDEF, 2);
        do_txn(64'h8, 8'h00, 64'h0);

        // Reset while a write waits: nothing written, counters cleared.
        req.valid  = 1'b1;
        req.addr   = 64'h18;
        req.strobe = 8'hFF;
        req.data   = 64'hFFFF0000FFFF0000;
        step();
        check_eq("rstw_busy_pre", 64'(busy), 64'd1);
        #2 rst = 1'b0;
        #1;
        check_eq("rstw_busy", 64'(busy), 64'd0);
        check_eq("rstw_txn", 64'(txn), 64'd0);
        check_eq("rstw_ok", 64'({resp.addr_ok, resp.data_ok}), 64'd0);
        check_eq("rstw_data", resp.data, 64'd0);
        txn_m = 32'd0;
        step();
        req.valid = 1'b0;
        rst = 1'b1;
        do_txn(64'h18, 8'h00, 64'h0);

        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 9);
            d = {$urandom, $urandom};
            if (r == 0) abort_txn(rand_addr($urandom_range(0, 7)), 8'($urandom), d, 1);
            else if (r == 1) abort_txn(rand_addr($urandom_range(0, 7)), 8'($urandom), d, 2);
            else do_txn(rand_addr($urandom_range(0, 7)),
                        ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom), d);
            repeat ($urandom_range(0, 2)) step();
        end

        // LATENCY=1 instance: valid held high, same write repeated.
        check_eq("b2b_txn_start", 64'(txn1), 64'd0);
        d = 64'hA5A5_5A5A_0F0F_F0F0;
        req1.valid  = 1'b1;
        req1.addr   = 64'h28;
        req1.size   = MSIZE8;
        req1.strobe = 8'hFF;
        req1.data   = d;
        for (int k = 1; k <= 8; k++) begin
            step();
            check_eq("b2b_dok", 64'(resp1.data_ok), 64'(k % 2));
            if (k % 2 == 1 && k > 1) check_eq("b2b_data", resp1.data, d);
        end
        req1.valid = 1'b0;
        step();
        check_eq("b2b_busy", 64'(busy1), 64'd0);
        check_eq("b2b_txn", 64'(txn1), 64'd4);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
